// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned TO_CNT_W = 8;
  localparam int unsigned STARV_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_MEM,
    RESP
  } ArbState_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_MEM
  } Owner_t;

  typedef struct packed {
    logic              Write;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic [BE_W-1:0]   ByteEn;
  } MemRequest_t;

  // Word accesses only; any nonzero low address bits are rejected without a bus cycle.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// IF, MEM and external bus signals of the memory port arbiter bundled as one interface.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_IF_Req;
  logic [ADDR_W-1:0] i_IF_Addr;
  logic              o_IF_Ready;
  logic              o_IF_Valid;
  logic [DATA_W-1:0] o_IF_RData;
  logic              o_IF_Error;

  logic              i_MEM_Req;
  logic              i_MEM_Write;
  logic [ADDR_W-1:0] i_MEM_Addr;
  logic [DATA_W-1:0] i_MEM_WData;
  logic [BE_W-1:0]   i_MEM_ByteEn;
  logic              o_MEM_Ready;
  logic              o_MEM_Valid;
  logic [DATA_W-1:0] o_MEM_RData;
  logic              o_MEM_Error;

  logic              o_Bus_Req;
  logic              o_Bus_Write;
  logic [ADDR_W-1:0] o_Bus_Addr;
  logic [DATA_W-1:0] o_Bus_WData;
  logic [BE_W-1:0]   o_Bus_ByteEn;
  logic              i_Bus_Ack;
  logic [DATA_W-1:0] i_Bus_RData;

  logic              o_Busy;

  // Arbiter side.
  modport slave (
    input  i_IF_Req, i_IF_Addr,
    output o_IF_Ready, o_IF_Valid, o_IF_RData, o_IF_Error,
    input  i_MEM_Req, i_MEM_Write, i_MEM_Addr, i_MEM_WData, i_MEM_ByteEn,
    output o_MEM_Ready, o_MEM_Valid, o_MEM_RData, o_MEM_Error,
    output o_Bus_Req, o_Bus_Write, o_Bus_Addr, o_Bus_WData, o_Bus_ByteEn,
    input  i_Bus_Ack, i_Bus_RData,
    output o_Busy
  );

  // Pipeline stages and bus model side.
  modport master (
    output i_IF_Req, i_IF_Addr,
    input  o_IF_Ready, o_IF_Valid, o_IF_RData, o_IF_Error,
    output i_MEM_Req, i_MEM_Write, i_MEM_Addr, i_MEM_WData, i_MEM_ByteEn,
    input  o_MEM_Ready, o_MEM_Valid, o_MEM_RData, o_MEM_Error,
    input  o_Bus_Req, o_Bus_Write, o_Bus_Addr, o_Bus_WData, o_Bus_ByteEn,
    output i_Bus_Ack, i_Bus_RData,
    input  o_Busy
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision for the shared port: MEM first, unless IF has waited through MEM_BURST_MAX MEM grants.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BURST_MAX = 4
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic idle,
  input  logic if_req,
  input  logic mem_req,
  output logic grant_if_c,
  output logic grant_mem_c
);

  logic [STARV_W-1:0] starv_q, starv_d;
  logic               mem_below_c;

  always_comb begin
    grant_if_c  = 1'b0;
    grant_mem_c = 1'b0;
    starv_d     = starv_q;
    mem_below_c = starv_q < STARV_W'(MEM_BURST_MAX);
    if (idle) begin
      if (mem_req && mem_below_c) begin
        grant_mem_c = 1'b1;
      end else if (if_req) begin
        grant_if_c = 1'b1;
      end else if (mem_req) begin
        grant_mem_c = 1'b1;
      end
      // Count MEM wins only while IF is actually waiting; saturates because MEM stops winning at the limit.
      if (!if_req || grant_if_c) begin
        starv_d = '0;
      end else if (grant_mem_c && mem_below_c) begin
        starv_d = starv_q + STARV_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      starv_q <= '0;
    end else begin
      starv_q <= starv_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and the memory stage, one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MEM_BURST_MAX  = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  mem_port_arbiter_if.slave port_if
);

  ArbState_t           state_q, state_d;
  Owner_t              owner_q, owner_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic                bus_req_q, bus_req_d;
  MemRequest_t         bus_q, bus_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_err_q, mem_err_d;
  logic                busy_q, busy_d;

  logic                idle_c;
  logic                grant_if_c, grant_mem_c;
  MemRequest_t         if_req_c, mem_req_c, gnt_req_c;

  assign idle_c = (state_q == IDLE);

  mem_arb_grant #(
    .MEM_BURST_MAX(MEM_BURST_MAX)
  ) u_grant (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .idle       (idle_c),
    .if_req     (port_if.i_IF_Req),
    .mem_req    (port_if.i_MEM_Req),
    .grant_if_c (grant_if_c),
    .grant_mem_c(grant_mem_c)
  );

  // Requests of both stages in a common shape; IF is always a full-word read.
  always_comb begin
    if_req_c        = '0;
    if_req_c.Addr   = port_if.i_IF_Addr;
    if_req_c.ByteEn = '1;
    mem_req_c.Write  = port_if.i_MEM_Write;
    mem_req_c.Addr   = port_if.i_MEM_Addr;
    mem_req_c.WData  = port_if.i_MEM_WData;
    mem_req_c.ByteEn = port_if.i_MEM_ByteEn;
    gnt_req_c = grant_mem_c ? mem_req_c : if_req_c;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    to_cnt_d    = to_cnt_q;
    bus_req_d   = bus_req_q;
    bus_d       = bus_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = '0;
    if_err_d    = 1'b0;
    mem_valid_d = 1'b0;
    mem_rdata_d = '0;
    mem_err_d   = 1'b0;
    to_cnt_inc  = to_cnt_q + TO_CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (grant_if_c || grant_mem_c) begin
          owner_d  = grant_mem_c ? OWNER_MEM : OWNER_IF;
          to_cnt_d = '0;
          rdata_d  = '0;
          if (is_misaligned(gnt_req_c.Addr[1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d          = grant_mem_c ? BUS_MEM : BUS_IF;
            err_d            = 1'b0;
            bus_req_d        = 1'b1;
            bus_d            = gnt_req_c;
            bus_d.Addr[1:0]  = 2'b00;
          end
        end
      end

      BUS_IF, BUS_MEM: begin
        // An ack on the final allowed cycle still completes the transaction normally.
        if (port_if.i_Bus_Ack) begin
          state_d   = RESP;
          rdata_d   = bus_q.Write ? '0 : port_if.i_Bus_RData;
          err_d     = 1'b0;
          bus_req_d = 1'b0;
          bus_d     = '0;
          to_cnt_d  = '0;
        end else if (to_cnt_inc == TO_CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = RESP;
          rdata_d   = '0;
          err_d     = 1'b1;
          bus_req_d = 1'b0;
          bus_d     = '0;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      RESP: begin
        state_d = IDLE;
        if (owner_q == OWNER_MEM) begin
          mem_valid_d = 1'b1;
          mem_rdata_d = rdata_q;
          mem_err_d   = err_q;
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = rdata_q;
          if_err_d   = err_q;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      to_cnt_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      to_cnt_q    <= to_cnt_d;
      bus_req_q   <= bus_req_d;
      bus_q       <= bus_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      mem_valid_q <= mem_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_err_q   <= mem_err_d;
      busy_q      <= busy_d;
    end
  end

  assign port_if.o_IF_Ready   = grant_if_c;
  assign port_if.o_IF_Valid   = if_valid_q;
  assign port_if.o_IF_RData   = if_rdata_q;
  assign port_if.o_IF_Error   = if_err_q;
  assign port_if.o_MEM_Ready  = grant_mem_c;
  assign port_if.o_MEM_Valid  = mem_valid_q;
  assign port_if.o_MEM_RData  = mem_rdata_q;
  assign port_if.o_MEM_Error  = mem_err_q;
  assign port_if.o_Bus_Req    = bus_req_q;
  assign port_if.o_Bus_Write  = bus_q.Write;
  assign port_if.o_Bus_Addr   = bus_q.Addr;
  assign port_if.o_Bus_WData  = bus_q.WData;
  assign port_if.o_Bus_ByteEn = bus_q.ByteEn;
  assign port_if.o_Busy       = busy_q;

endmodule
